// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: opcodes, FSM encoding, instruction fields.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W = 19;
    localparam int OP_W   = 5;
    localparam int NREGS  = 8;
    localparam int ADDR_W = 3;

    // Opcode map of the external ALU; anything above OP_LAST is illegal.
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00001;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00010;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00011;
    localparam logic [OP_W-1:0] OP_XOR  = 5'b00100;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_INC  = 5'b01000;
    localparam logic [OP_W-1:0] OP_DEC  = 5'b01001;
    localparam logic [OP_W-1:0] OP_LAST = 5'b01001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // Instruction word layout: [18:14] opcode, [13:11] rd, [10:8] rs1, [7:5] rs2, [4:0] reserved.
    localparam int OP_MSB  = 18;
    localparam int OP_LSB  = 14;
    localparam int RD_MSB  = 13;
    localparam int RD_LSB  = 11;
    localparam int RS1_MSB = 10;
    localparam int RS1_LSB = 8;
    localparam int RS2_MSB = 7;
    localparam int RS2_LSB = 5;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_LAST);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x19 register file: one synchronous write port (writeback has priority over host), three comb reads.
// Latency: write visible on reads the cycle after the write edge; reads are combinational.
// Backpressure: none; the controller guarantees writeback and host writes never coincide.
//
// Ports:
//   clk, rst                         clock and synchronous active-high reset (clears all entries)
//   i_wb_we/i_wb_addr/i_wb_data      writeback write request from the controller
//   i_host_we/i_host_addr/i_host_data host write request (already qualified by the controller)
//   i_raddr_a/o_rdata_a              operand A read port
//   i_raddr_b/o_rdata_b              operand B read port
//   i_raddr_h/o_rdata_h              host observation read port
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_data,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    input  logic [ADDR_W-1:0] i_raddr_h,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b,
    output logic [DATA_W-1:0] o_rdata_h
);

    logic [DATA_W-1:0] r_regs [NREGS];

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_we    = i_wb_we | i_host_we;
    assign w_waddr = i_wb_we ? i_wb_addr : i_host_addr;
    assign w_wdata = i_wb_we ? i_wb_data : i_host_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[w_waddr] <= w_wdata;
        end
    end

    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];
    assign o_rdata_h = r_regs[i_raddr_h];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller driving an external combinational ALU: accept, read operands, execute, write back.
// Latency: accept at edge N, done pulses in cycle N+3; one instruction every 4 cycles.
// Backpressure: instr_ready is high only in IDLE; host writes outside IDLE are dropped.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   instr_valid/instr_ready/instr  instruction handshake and word
//   alu_opcode/alu_r2/alu_r3       registered drive to the ALU (held between instructions)
//   alu_r1/alu_zero                ALU result and zero flag
//   host_we/host_waddr/host_wdata  host register write (IDLE only)
//   host_raddr/host_rdata          combinational host register read
//   done/illegal                   one-cycle retire pulses
//   wb_data/zero_flag              held result and zero flag of the last retired instruction
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [DATA_W-1:0] instr,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_r2,
    output logic [DATA_W-1:0] alu_r3,
    input  logic [DATA_W-1:0] alu_r1,
    input  logic              alu_zero,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_waddr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [ADDR_W-1:0] host_raddr,
    output logic [DATA_W-1:0] host_rdata,
    output logic              done,
    output logic [DATA_W-1:0] wb_data,
    output logic              zero_flag,
    output logic              illegal
);

    state_t            r_state;
    logic [OP_W-1:0]   r_op;
    logic [ADDR_W-1:0] r_rd;
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic [OP_W-1:0]   r_alu_op;
    logic [DATA_W-1:0] r_alu_r2;
    logic [DATA_W-1:0] r_alu_r3;
    logic [DATA_W-1:0] r_res;
    logic              r_res_zero;
    logic              r_done;
    logic              r_illegal;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_zero_flag;

    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;
    logic              w_legal;
    logic              w_wb_we;
    logic              w_host_we;
    logic              w_unused_rsvd;

    // Reserved instruction bits carry no meaning.
    assign w_unused_rsvd = ^instr[RS2_LSB-1:0];

    assign w_legal   = op_is_legal(r_op);
    assign w_wb_we   = (r_state == ST_WB) && w_legal;
    // Host writes only land in IDLE, so they can never collide with writeback.
    assign w_host_we = host_we && (r_state == ST_IDLE);

    alu_regfile u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_wb_we     (w_wb_we),
        .i_wb_addr   (r_rd),
        .i_wb_data   (r_res),
        .i_host_we   (w_host_we),
        .i_host_addr (host_waddr),
        .i_host_data (host_wdata),
        .i_raddr_a   (r_rs1),
        .i_raddr_b   (r_rs2),
        .i_raddr_h   (host_raddr),
        .o_rdata_a   (w_rs1_data),
        .o_rdata_b   (w_rs2_data),
        .o_rdata_h   (host_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_alu_op    <= '0;
            r_alu_r2    <= '0;
            r_alu_r3    <= '0;
            r_res       <= '0;
            r_res_zero  <= 1'b0;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
            r_wb_data   <= '0;
            r_zero_flag <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        r_op    <= instr[OP_MSB:OP_LSB];
                        r_rd    <= instr[RD_MSB:RD_LSB];
                        r_rs1   <= instr[RS1_MSB:RS1_LSB];
                        r_rs2   <= instr[RS2_MSB:RS2_LSB];
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Operands are sampled here, before writeback, so rd==rs uses the old value.
                    r_alu_op <= r_op;
                    r_alu_r2 <= w_rs1_data;
                    r_alu_r3 <= w_rs2_data;
                    r_state  <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_res      <= alu_r1;
                    r_res_zero <= alu_zero;
                    r_state    <= ST_WB;
                end
                ST_WB: begin
                    r_done <= 1'b1;
                    if (w_legal) begin
                        r_wb_data   <= r_res;
                        r_zero_flag <= r_res_zero;
                    end else begin
                        r_wb_data <= '0;
                        r_illegal <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready = (r_state == ST_IDLE);
    assign alu_opcode  = r_alu_op;
    assign alu_r2      = r_alu_r2;
    assign alu_r3      = r_alu_r3;
    assign done        = r_done;
    assign illegal     = r_illegal;
    assign wb_data     = r_wb_data;
    assign zero_flag   = r_zero_flag;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural model of the external ALU.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [18:0] instr;
    logic [4:0]  alu_opcode;
    logic [18:0] alu_r2;
    logic [18:0] alu_r3;
    logic [18:0] alu_r1;
    logic        alu_zero;
    logic        host_we;
    logic [2:0]  host_waddr;
    logic [18:0] host_wdata;
    logic [2:0]  host_raddr;
    logic [18:0] host_rdata;
    logic        done;
    logic [18:0] wb_data;
    logic        zero_flag;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_opcode  (alu_opcode),
        .alu_r2      (alu_r2),
        .alu_r3      (alu_r3),
        .alu_r1      (alu_r1),
        .alu_zero    (alu_zero),
        .host_we     (host_we),
        .host_waddr  (host_waddr),
        .host_wdata  (host_wdata),
        .host_raddr  (host_raddr),
        .host_rdata  (host_rdata),
        .done        (done),
        .wb_data     (wb_data),
        .zero_flag   (zero_flag),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; undefined opcodes give a nonzero pattern so a wrongly captured zero flag shows.
    always_comb begin
        alu_r1 = '0;
        case (alu_opcode)
            5'd0:    alu_r1 = alu_r2 + alu_r3;
            5'd1:    alu_r1 = alu_r2 - alu_r3;
            5'd2:    alu_r1 = alu_r2 & alu_r3;
            5'd3:    alu_r1 = alu_r2 | alu_r3;
            5'd4:    alu_r1 = alu_r2 ^ alu_r3;
            5'd5:    alu_r1 = ~alu_r2;
            5'd6:    alu_r1 = alu_r2 << 1;
            5'd7:    alu_r1 = alu_r2 >> 1;
            5'd8:    alu_r1 = alu_r2 + 19'd1;
            5'd9:    alu_r1 = alu_r2 - 19'd1;
            default: alu_r1 = alu_r2 ^ 19'h5A5A5;
        endcase
    end
    assign alu_zero = (alu_r1 == 19'd0);

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
        $fatal(1, "watchdog");
    end

    // All tasks start and end at 1ns after a rising edge.
    task automatic host_write(input logic [2:0] a, input logic [18:0] d);
        host_we    = 1'b1;
        host_waddr = a;
        host_wdata = d;
        @(posedge clk); #1;
        host_we    = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [18:0] d);
        host_raddr = a;
        @(negedge clk);
        d = host_rdata;
        @(posedge clk); #1;
    endtask

    // Issues one instruction; lat = cycles from accept edge to done (-1 on timeout),
    // wb_rd = host_rdata sampled in the cycle before done (the WB cycle).
    task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, output int lat, output logic ill,
                         output logic [18:0] wb_rd);
        instr       = {op, rd, rs1, rs2, 5'b10101};
        instr_valid = 1'b1;
        lat   = -1;
        ill   = 1'b0;
        wb_rd = 'x;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr       = '0;
        for (int k = 0; k < 8; k++) begin
            if (done) begin
                lat = k;
                ill = illegal;
                break;
            end
            wb_rd = host_rdata;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [18:0] d;
        int nz;
        int pulses;
        rst = 1'b1; instr_valid = 1'b0; instr = '0;
        host_we = 1'b0; host_waddr = '0; host_wdata = '0; host_raddr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
        n_checks++; if (wb_data !== 19'd0) begin n_fail++; $display("FAIL reset_wb_data: got %h expected 0", wb_data); end
        n_checks++; if (zero_flag !== 1'b0) begin n_fail++; $display("FAIL reset_zero_flag: got %b expected 0", zero_flag); end
        n_checks++; if ({alu_opcode, alu_r2, alu_r3} !== 43'd0) begin n_fail++; $display("FAIL reset_alu_outs: got %h/%h/%h expected 0/0/0", alu_opcode, alu_r2, alu_r3); end

        // Start an instruction and reset it while in EXEC.
        host_write(3'd1, 19'd5);
        instr = {OP_ADD, 3'd3, 3'd1, 3'd1, 5'd0};
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (alu_r2 !== 19'd5) begin n_fail++; $display("FAIL midrst_operand_read: got %h expected 5", alu_r2); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", instr_ready); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
        n_checks++; if (alu_r2 !== 19'd0) begin n_fail++; $display("FAIL midrst_alu_r2: got %h expected 0", alu_r2); end
        nz = 0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || illegal) pulses++;
            read_reg(3'(i), d);
            if (d !== 19'd0) nz++;
        end
        n_checks++; if (nz != 0) begin n_fail++; $display("FAIL midrst_regs_clear: got %0d nonzero regs expected 0", nz); end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL midrst_no_pulse: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_add();
        int lat;
        logic ill;
        logic [18:0] pre, d;
        host_write(3'd1, 19'd5);
        host_write(3'd2, 19'd7);
        host_raddr = 3'd3;
        issue(OP_ADD, 3'd3, 3'd1, 3'd2, lat, ill, pre);
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL add_latency: got %0d expected 3", lat); end
        n_checks++; if (ill !== 1'b0) begin n_fail++; $display("FAIL add_illegal: got %b expected 0", ill); end
        n_checks++; if (pre !== 19'd0) begin n_fail++; $display("FAIL add_wb_cycle_read: got %h expected 0", pre); end
        n_checks++; if (wb_data !== 19'd12) begin n_fail++; $display("FAIL add_wb_data: got %h expected c", wb_data); end
        n_checks++; if (zero_flag !== 1'b0) begin n_fail++; $display("FAIL add_zero_flag: got %b expected 0", zero_flag); end
        n_checks++; if ({alu_opcode, alu_r2, alu_r3} !== {5'd0, 19'd5, 19'd7}) begin n_fail++; $display("FAIL add_alu_hold: got %h/%h/%h expected 0/5/7", alu_opcode, alu_r2, alu_r3); end
        read_reg(3'd3, d);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_one_cycle: got %b expected 0", done); end
        n_checks++; if (d !== 19'd12) begin n_fail++; $display("FAIL add_r3: got %h expected c", d); end
    endtask

    task automatic test_sub_hazard();
        int lat;
        logic ill;
        logic [18:0] pre, d;
        host_write(3'd4, 19'd9);
        host_raddr = 3'd4;
        issue(OP_SUB, 3'd4, 3'd4, 3'd4, lat, ill, pre);
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL sub_latency: got %0d expected 3", lat); end
        n_checks++; if (pre !== 19'd9) begin n_fail++; $display("FAIL sub_wb_cycle_read: got %h expected 9", pre); end
        n_checks++; if (wb_data !== 19'd0) begin n_fail++; $display("FAIL sub_wb_data: got %h expected 0", wb_data); end
        n_checks++; if (zero_flag !== 1'b1) begin n_fail++; $display("FAIL sub_zero_flag: got %b expected 1", zero_flag); end
        read_reg(3'd4, d);
        n_checks++; if (d !== 19'd0) begin n_fail++; $display("FAIL sub_r4: got %h expected 0", d); end
        issue(OP_DEC, 3'd5, 3'd4, 3'd0, lat, ill, pre);
        n_checks++; if (lat != 3 || ill !== 1'b0) begin n_fail++; $display("FAIL dec_latency: got %0d/%b expected 3/0", lat, ill); end
        n_checks++; if (wb_data !== 19'h7FFFF) begin n_fail++; $display("FAIL dec_wb_data: got %h expected 7ffff", wb_data); end
        n_checks++; if (zero_flag !== 1'b0) begin n_fail++; $display("FAIL dec_zero_flag: got %b expected 0", zero_flag); end
        read_reg(3'd5, d);
        n_checks++; if (d !== 19'h7FFFF) begin n_fail++; $display("FAIL dec_r5: got %h expected 7ffff", d); end
    endtask

    task automatic test_illegal();
        int lat;
        logic ill;
        logic [18:0] pre, d;
        issue(OP_SUB, 3'd7, 3'd0, 3'd0, lat, ill, pre);
        n_checks++; if (zero_flag !== 1'b1) begin n_fail++; $display("FAIL ill_setup_zero: got %b expected 1", zero_flag); end
        issue(5'b01010, 3'd2, 3'd1, 3'd1, lat, ill, pre);
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL ill_latency: got %0d expected 3", lat); end
        n_checks++; if (ill !== 1'b1) begin n_fail++; $display("FAIL ill_pulse_with_done: got %b expected 1", ill); end
        n_checks++; if (wb_data !== 19'd0) begin n_fail++; $display("FAIL ill_wb_data: got %h expected 0", wb_data); end
        n_checks++; if (zero_flag !== 1'b1) begin n_fail++; $display("FAIL ill_zero_kept: got %b expected 1", zero_flag); end
        read_reg(3'd2, d);
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL ill_one_cycle: got %b expected 0", illegal); end
        n_checks++; if (d !== 19'd7) begin n_fail++; $display("FAIL ill_r2_kept: got %h expected 7", d); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] mask;
        int got_done;
        logic [18:0] d;
        mask = '0;
        instr = {OP_ADD, 3'd6, 3'd1, 3'd2, 5'd0};
        instr_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            mask[c] = instr_ready;
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        instr = '0;
        n_checks++; if (mask !== 10'b01_0001_0001) begin n_fail++; $display("FAIL b2b_accept_cycles: got %b expected 0100010001", mask); end
        got_done = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) begin
                got_done = 1;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++; if (got_done != 1) begin n_fail++; $display("FAIL b2b_last_done: got %0d expected 1", got_done); end
        read_reg(3'd6, d);
        n_checks++; if (d !== 19'd12) begin n_fail++; $display("FAIL b2b_r6: got %h expected c", d); end
    endtask

    task automatic test_host_collision();
        logic [18:0] d;
        instr = {OP_ADD, 3'd6, 3'd1, 3'd1, 5'd0};
        instr_valid = 1'b1;
        host_we = 1'b1; host_waddr = 3'd1; host_wdata = 19'd3;
        @(posedge clk); #1;
        instr_valid = 1'b0; host_we = 1'b0;
        @(posedge clk); #1;
        host_we = 1'b1; host_waddr = 3'd7; host_wdata = 19'h01234;
        @(posedge clk); #1;
        host_we = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL coll_done: got %b expected 1", done); end
        n_checks++; if (wb_data !== 19'd6) begin n_fail++; $display("FAIL coll_wb_data: got %h expected 6", wb_data); end
        read_reg(3'd6, d);
        n_checks++; if (d !== 19'd6) begin n_fail++; $display("FAIL coll_r6: got %h expected 6", d); end
        read_reg(3'd1, d);
        n_checks++; if (d !== 19'd3) begin n_fail++; $display("FAIL coll_r1: got %h expected 3", d); end
        read_reg(3'd7, d);
        n_checks++; if (d !== 19'd0) begin n_fail++; $display("FAIL coll_exec_write_ignored: got %h expected 0", d); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_hazard();
        test_illegal();
        test_back_to_back();
        test_host_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
